memoria_ram_dp_clr: RTL and testbench

//   Parametrised simple-dual-port synchronous RAM: one write port, one read port.
//   Per-byte write enables, 1-cycle registered read with valid flag.

---
 rtl/memoria_ram_dp_clr.sv | 114 +++++++++++
 tb/tb_memoria_ram_dp_clr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_ram_dp_clr.sv
// memoria_ram_dp_clr: simple-dual-port RAM (one write port, one read port) with byte
// enables and a hardware clear engine that writes CLR_VALUE to every word.
// Latency: read data registered, rd_valid/rd_data one cycle after rd_en; a clear takes DEPTH cycles.
// Backpressure: none. While busy=1, write and read requests are dropped, not stalled.
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   clr_req / busy       start a full-array clear / clear engine running
//   wr_en, wr_addr, wr_data, wr_be   write port, wr_be[i] covers wr_data[8i+7:8i]
//   rd_en, rd_addr       read request
//   rd_valid, rd_data    registered read result for the request accepted last cycle
//
// Build option: define MEM_BYPASS_EN for write-first behaviour on a same-address
// read/write collision. Without it, a colliding read returns the word as it was
// before the write (read-first).

module memoria_ram_dp_clr #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr_req,
    output logic                      busy,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      rd_valid,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam int                    NBYTES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [DATA_WIDTH-1:0]   ram [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;

    // Word presented to the read register. The array itself is read-first;
    // the optional bypass overlays the lanes being written this cycle.
    always_comb begin
        rd_word = ram[rd_addr];
`ifdef MEM_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
`endif
    end

    // Storage has no reset; the clear sweep that follows every reset
    // initialises it. Port writes are ignored while the sweep owns the array.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            ram[clr_ptr] <= CLR_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    ram[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Control FSM; busy mirrors state==CLEAR but is kept as a registered output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    // Pointer wraps to 0 naturally after the last word.
                    clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
                    if (clr_ptr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    // A read in the same cycle as clr_req is still served.
                    if (rd_en) begin
                        rd_valid <= 1'b1;
                        rd_data  <= rd_word;
                    end
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_ram_dp_clr.sv
module tb_memoria_ram_dp_clr;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] CLR = 16'h0000;

`ifdef MEM_BYPASS_EN
    localparam logic [DW-1:0] COLL_EXP = 16'hAAAA;
`else
    localparam logic [DW-1:0] COLL_EXP = 16'h5555;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NB-1:0] wr_be = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain array plus "words still to clear" count.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left = DEPTH;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;

    memoria_ram_dp_clr #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLR_VALUE  (CLR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        wr_be   = '0;
        rd_en   = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, clock the DUT,
    // then compare all outputs 1 time unit after the edge.
    task automatic cycle(input string tag);
        logic [DW-1:0] old;
        if (m_left > 0) begin
            m_mem[DEPTH - m_left] = CLR;
            m_left--;
            m_valid = 1'b0;
        end else begin
            old = m_mem[rd_addr];
            if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) m_mem[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
            m_valid = rd_en;
            if (rd_en) begin
`ifdef MEM_BYPASS_EN
                m_data = m_mem[rd_addr];
`else
                m_data = old;
`endif
            end
            if (clr_req) m_left = DEPTH;
        end
        @(posedge clk);
        #1;
        chk({tag, " busy"},     32'(busy),     32'(m_left > 0));
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(m_valid));
        chk({tag, " rd_data"},  32'(rd_data),  32'(m_data));
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        m_left  = DEPTH;
        m_valid = 1'b0;
        m_data  = '0;
        chk({tag, " reset busy"},     32'(busy),     32'd1);
        chk({tag, " reset rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, " reset rd_data"},  32'(rd_data),  32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic count_busy(input string tag, output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            cycle(tag);
            n++;
        end
    endtask

    typedef struct packed {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic [NB-1:0] wr_be;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        int n;

        vecs[0]  = '{1'b1, 4'd3, 16'hBEEF, 2'b11, 1'b0, 4'd0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'hBEEF};
        vecs[2]  = '{1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 1'b0, 16'hBEEF};
        vecs[3]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'hBE34};
        vecs[4]  = '{1'b1, 4'd5, 16'h5555, 2'b11, 1'b0, 4'd0, 1'b0, 16'hBE34};
        vecs[5]  = '{1'b1, 4'd5, 16'hAAAA, 2'b11, 1'b1, 4'd5, 1'b1, COLL_EXP};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 16'hAAAA};
        vecs[7]  = '{1'b1, 4'd9, 16'h1234, 2'b10, 1'b0, 4'd0, 1'b0, 16'hAAAA};
        vecs[8]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd9, 1'b1, 16'h1200};
        vecs[9]  = '{1'b1, 4'd9, 16'hFFFF, 2'b00, 1'b1, 4'd9, 1'b1, 16'h1200};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd9, 1'b1, 16'h1200};
        vecs[11] = '{1'b1, 4'd7, 16'h7777, 2'b11, 1'b0, 4'd0, 1'b0, 16'h1200};

        // Power-on reset and initial sweep.
        idle();
        @(posedge clk);
        #1;
        do_reset("por");
        count_busy("por sweep", n);
        chk("por sweep length", 32'(n), 32'(DEPTH));

        for (int a = 0; a < DEPTH; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            cycle("init read");
            chk("init read word", 32'(rd_data), 32'(CLR));
        end
        idle();

        // Directed vectors.
        for (int r = 0; r < NV; r++) begin
            wr_en   = vecs[r].wr_en;
            wr_addr = vecs[r].wr_addr;
            wr_data = vecs[r].wr_data;
            wr_be   = vecs[r].wr_be;
            rd_en   = vecs[r].rd_en;
            rd_addr = vecs[r].rd_addr;
            cycle($sformatf("vec%0d", r));
            chk($sformatf("vec%0d valid", r), 32'(rd_valid), 32'(vecs[r].exp_valid));
            chk($sformatf("vec%0d data", r),  32'(rd_data),  32'(vecs[r].exp_data));
        end

        // clr_req with a write and a read in the same cycle: both still performed.
        clr_req = 1'b1;
        wr_en   = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777; wr_be = 2'b11;
        rd_en   = 1'b1; rd_addr = 4'd9;
        cycle("clr start");
        chk("clr start busy", 32'(busy), 32'd1);
        chk("clr start read", 32'(rd_data), 32'h1200);

        // During the sweep: repeated clr_req ignored, writes/reads dropped.
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            clr_req = 1'b1;
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hDEAD; wr_be = 2'b11;
            rd_en = 1'b1; rd_addr = AW'($urandom);
            cycle("clr sweep");
            chk("clr sweep rd_valid", 32'(rd_valid), 32'd0);
            n++;
        end
        chk("clr sweep length", 32'(n), 32'(DEPTH));
        idle();
        rd_en = 1'b1; rd_addr = 4'd7;
        cycle("after clr addr7");
        chk("after clr addr7 data", 32'(rd_data), 32'h0000);
        rd_addr = 4'd0;
        cycle("after clr addr0");
        chk("after clr addr0 data", 32'(rd_data), 32'h0000);
        idle();

        // Reset in the middle of a sweep, at clr_ptr = 9.
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hABCD; wr_be = 2'b11;
        cycle("pre mid wr");
        idle();
        rd_en = 1'b1; rd_addr = 4'd2; clr_req = 1'b1;
        cycle("pre mid rd");
        chk("pre mid rd data", 32'(rd_data), 32'hABCD);
        idle();
        repeat (9) cycle("mid sweep");
        do_reset("mid sweep");
        count_busy("mid restart", n);
        chk("mid restart length", 32'(n), 32'(DEPTH));

        // Reset with a read outstanding: rd_valid drops at once.
        rd_en = 1'b1; rd_addr = 4'd2;
        cycle("rd before rst");
        chk("rd before rst valid", 32'(rd_valid), 32'd1);
        idle();
        do_reset("rd outstanding");
        count_busy("rd outstanding sweep", n);
        chk("rd outstanding sweep length", 32'(n), 32'(DEPTH));

        // Randomized traffic against the model, with frequent collisions.
        for (int k = 0; k < 800; k++) begin
            wr_en   = 1'($urandom);
            wr_addr = AW'($urandom);
            wr_data = DW'($urandom);
            wr_be   = NB'($urandom);
            rd_en   = 1'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            clr_req = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
